// File: rtl/combo_lock_pkg.sv
// Shared definitions for the combination-lock controller: state encoding,
// LED bit positions and the LED packing helper.
package combo_lock_pkg;

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  localparam int LED_OPEN      = 0;
  localparam int LED_LOCK      = 1;
  localparam int LED_FAIL_LO   = 2;
  localparam int LED_FAIL_HI   = 3;
  localparam int LED_LAST_FAIL = 4;

  function automatic logic [15:0] led_map(input state_t st, input logic [1:0] fail_cnt,
                                          input logic last_fail);
    logic [15:0] led;
    led = 16'h0000;
    led[LED_OPEN]                  = (st == OPEN);
    led[LED_LOCK]                  = (st == LOCKOUT);
    led[LED_FAIL_HI:LED_FAIL_LO]   = fail_cnt;
    led[LED_LAST_FAIL]             = last_fail;
    return led;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioner: 2-FF synchronizer, stability counter and a
// registered one-cycle pulse on each debounced rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1, sync2, level;
  logic [CW-1:0] cnt;

  // The counter runs only while the synchronized input disagrees with the
  // debounced level; any return to agreement restarts the stability window.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      pulse <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        pulse <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/combo_lock_ctrl.sv
// Board top for the combination lock: debounced Enter/Set-key buttons, key
// register, failed-attempt counter with timed lockout, and status LEDs.
module combo_lock_ctrl
  import combo_lock_pkg::*;
#(
  parameter int              CODE_W          = 3,
  parameter logic [CODE_W-1:0] KEY_RESET     = 3'b000,
  parameter int              MAX_TRIES       = 3,
  parameter int              DEBOUNCE_CYCLES = 1000000,
  parameter int              LOCKOUT_CYCLES  = 500000000
) (
  input  logic        clk_pin,
  input  logic        rst_pin,
  input  logic [7:0]  sw_pin,
  input  logic [1:0]  btn_pin,
  output logic [15:0] led_pin
);

  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);

  logic enter_p, set_p;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk(clk_pin), .rst(rst_pin), .raw(btn_pin[0]), .pulse(enter_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
    .clk(clk_pin), .rst(rst_pin), .raw(btn_pin[1]), .pulse(set_p)
  );

  state_t            state_q, state_d;
  logic [CODE_W-1:0] key_q, key_d;
  logic [1:0]        fail_q, fail_d;
  logic              last_q, last_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              match;
  logic              unused_sw;

  assign unused_sw = ^sw_pin[4:3];
  assign match     = (sw_pin[CODE_W-1:0] == key_q);

  always_ff @(posedge clk_pin) begin
    if (rst_pin) begin
      state_q <= LOCKED;
      key_q   <= KEY_RESET;
      fail_q  <= 2'd0;
      last_q  <= 1'b0;
      timer_q <= '0;
      led_pin <= 16'h0000;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      fail_q  <= fail_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      led_pin <= led_map(state_d, fail_d, last_d);
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    fail_d  = fail_q;
    last_d  = last_q;
    timer_d = timer_q;
    case (state_q)
      LOCKED: begin
        if (enter_p) begin
          if (match) begin
            state_d = OPEN;
            fail_d  = 2'd0;
            last_d  = 1'b0;
          end else begin
            last_d = 1'b1;
            if (({1'b0, fail_q} + 3'd1) == 3'(MAX_TRIES)) begin
              state_d = LOCKOUT;
              timer_d = TW'(LOCKOUT_CYCLES - 1);
              fail_d  = 2'(MAX_TRIES);
            end else begin
              fail_d = fail_q + 2'd1;
            end
          end
        end
      end
      OPEN: begin
        // Enter takes priority so a simultaneous Set-key never rewrites the key.
        if (enter_p) begin
          state_d = LOCKED;
        end else if (set_p) begin
          key_d = sw_pin[5 +: CODE_W];
        end
      end
      LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = LOCKED;
          fail_d  = 2'd0;
          last_d  = 1'b0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = LOCKED;
    endcase
  end

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed bench for combo_lock_ctrl with short debounce and lockout windows.
module tb_combo_lock_ctrl;

  logic        clk_pin = 1'b0;
  logic        rst_pin;
  logic [7:0]  sw_pin;
  logic [1:0]  btn_pin;
  logic [15:0] led_pin;

  int n_vec  = 0;
  int n_miss = 0;

  combo_lock_ctrl #(
    .CODE_W(3), .KEY_RESET(3'b000), .MAX_TRIES(3),
    .DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(20)
  ) dut (
    .clk_pin(clk_pin), .rst_pin(rst_pin), .sw_pin(sw_pin),
    .btn_pin(btn_pin), .led_pin(led_pin)
  );

  always #5 clk_pin = ~clk_pin;

  typedef struct {
    string       name;
    logic [7:0]  sw;
    logic [1:0]  btn;
    int          hold;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: led_pin=%h required %h", name, act, exp);
    end
  endtask

  // Drive inputs after a falling edge, hold for 'hold' rising edges, release
  // and leave time for the release to debounce.
  task automatic press(input logic [7:0] sw, input logic [1:0] btn, input int hold);
    @(negedge clk_pin);
    sw_pin  = sw;
    btn_pin = btn;
    repeat (hold) @(negedge clk_pin);
    btn_pin = 2'b00;
    repeat (12) @(negedge clk_pin);
  endtask

  task automatic wait_lockout(input string name, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_pin);
      if (led_pin[1]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: led_pin=%h required lockout bit within 40 cycles", name, led_pin);
    end
  endtask

  initial begin
    bit seen;

    rst_pin = 1'b1;
    sw_pin  = 8'h00;
    btn_pin = 2'b00;
    repeat (3) @(posedge clk_pin);
    @(negedge clk_pin);
    check("reset", led_pin, 16'h0000);
    rst_pin = 1'b0;

    // First press: pulse lands after 6 edges, LED updates on the 7th.
    @(negedge clk_pin);
    sw_pin  = 8'h00;
    btn_pin = 2'b01;
    repeat (6) @(negedge clk_pin);
    check("latency_before", led_pin, 16'h0000);
    @(negedge clk_pin);
    check("latency_open", led_pin, 16'h0001);
    repeat (3) @(negedge clk_pin);
    btn_pin = 2'b00;
    repeat (12) @(negedge clk_pin);
    check("held_one_pulse", led_pin, 16'h0001);

    vecs.push_back('{"relock",          8'h00, 2'b01, 10, 16'h0000});
    vecs.push_back('{"glitch",          8'h00, 2'b01,  2, 16'h0000});
    vecs.push_back('{"open_again",      8'h00, 2'b01, 10, 16'h0001});
    vecs.push_back('{"set_key_101",     8'hA0, 2'b10, 10, 16'h0001});
    vecs.push_back('{"relock2",         8'hA0, 2'b01, 10, 16'h0000});
    vecs.push_back('{"old_key_fails",   8'h00, 2'b01, 10, 16'h0014});
    vecs.push_back('{"new_key_opens",   8'h05, 2'b01, 10, 16'h0001});
    vecs.push_back('{"both_buttons",    8'h60, 2'b11, 10, 16'h0000});
    vecs.push_back('{"011_not_written", 8'h03, 2'b01, 10, 16'h0014});
    vecs.push_back('{"101_still_opens", 8'h05, 2'b01, 10, 16'h0001});
    vecs.push_back('{"relock3",         8'h05, 2'b01, 10, 16'h0000});
    vecs.push_back('{"set_when_locked", 8'hC0, 2'b10, 10, 16'h0000});
    vecs.push_back('{"110_fails",       8'h06, 2'b01, 10, 16'h0014});
    vecs.push_back('{"101_opens",       8'h05, 2'b01, 10, 16'h0001});
    vecs.push_back('{"relock4",         8'h05, 2'b01, 10, 16'h0000});
    vecs.push_back('{"wrong_1",         8'h07, 2'b01, 10, 16'h0014});
    vecs.push_back('{"wrong_2",         8'h07, 2'b01, 10, 16'h0018});

    foreach (vecs[i]) begin
      press(vecs[i].sw, vecs[i].btn, vecs[i].hold);
      check(vecs[i].name, led_pin, vecs[i].exp);
    end

    // Third wrong entry: lockout must last exactly 20 cycles and ignore Enter.
    @(negedge clk_pin);
    sw_pin  = 8'h07;
    btn_pin = 2'b01;
    wait_lockout("lockout_entry", seen);
    btn_pin = 2'b00;
    repeat (12) @(negedge clk_pin);
    if (seen) begin
      // Still locked out here (about 13 cycles in); let it expire before timing a fresh one.
      check("lockout_leds", led_pin, 16'h001E);
      repeat (10) @(negedge clk_pin);
      check("lockout_expired", led_pin, 16'h0000);
    end

    press(8'h07, 2'b01, 10);
    check("wrong_a", led_pin, 16'h0014);
    press(8'h07, 2'b01, 10);
    check("wrong_b", led_pin, 16'h0018);
    @(negedge clk_pin);
    sw_pin  = 8'h07;
    btn_pin = 2'b01;
    wait_lockout("lockout_timed", seen);
    if (seen) begin
      check("lockout_start", led_pin, 16'h001E);
      sw_pin  = 8'h05;
      btn_pin = 2'b00;
      for (int k = 1; k < 20; k++) begin
        @(negedge clk_pin);
        if (k == 2) btn_pin = 2'b01;
        if (k == 10) btn_pin = 2'b00;
        check($sformatf("lockout_hold_%0d", k), led_pin, 16'h001E);
      end
      @(negedge clk_pin);
      check("lockout_exit_20", led_pin, 16'h0000);
    end
    btn_pin = 2'b00;
    repeat (12) @(negedge clk_pin);
    check("after_lockout", led_pin, 16'h0000);

    // Reset at lockout cycle 10 restores the reset key.
    press(8'h07, 2'b01, 10);
    press(8'h07, 2'b01, 10);
    @(negedge clk_pin);
    btn_pin = 2'b01;
    wait_lockout("lockout_for_reset", seen);
    btn_pin = 2'b00;
    repeat (9) @(negedge clk_pin);
    rst_pin = 1'b1;
    @(negedge clk_pin);
    rst_pin = 1'b0;
    check("reset_mid_lockout", led_pin, 16'h0000);
    press(8'h00, 2'b01, 10);
    check("reset_key_opens", led_pin, 16'h0001);
    press(8'h00, 2'b01, 10);
    check("relock5", led_pin, 16'h0000);
    press(8'h05, 2'b01, 10);
    check("old_key_gone", led_pin, 16'h0014);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
